spart_fifo: RTL
===============

Name: spart_fifo

Overview:
- Parametrised successor to the single-byte SPART: programmable-baud UART with TX and RX FIFOs, sticky error status and an interrupt output.
- Sits on the processor I/O bus (iocs/iorw/ioaddr/databus), drives txd and samples rxd.
- Adds configurable data width and FIFO depth, 16x oversampled receive with start-bit validation, framing/overrun detection, and a status register.

Parameters:
- DATA_BITS, 8, frame data bits (5..8); unused upper databus bits read 0.
- FIFO_DEPTH, 8, entries per TX and RX FIFO; must be a power of 2, minimum 2.
- DIV_RESET, 16'd650, divisor reset value (9600 baud at 100 MHz with 16x oversampling).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- iocs  in  1  chip select
- iorw  in  1  1 = read, 0 = write
- ioaddr  in  2  00 data, 01 status/control, 10 divisor low, 11 divisor high
- databus  inout  8  driven only when iocs & iorw, else high-Z
- rxd  in  1  serial input, asynchronous
- txd  out  1  serial output, idles high
- rda  out  1  RX FIFO not empty
- tbr  out  1  TX FIFO not full
- irq  out  1  rda | any sticky error

Behaviour:
- Reset (asynchronous, rst_n=0):
  - txd=1; rda=0; tbr=1; irq=0.
  - FIFOs empty; divisor=DIV_RESET; error bits 0; both FSMs IDLE.
  - Reset asserted mid-frame aborts the frame immediately; txd returns high in the same cycle.
- Baud generator:
  - 16-bit down counter, reload from divisor; one-cycle tick when it reaches 0, i.e. every divisor+1 clk.
  - Tick rate is 16x baud.
  - A divisor write takes effect at the next reload; a frame in progress is not restarted.
- Writes (iocs & ~iorw), one cycle each:
  - 00: push databus[DATA_BITS-1:0] to TX FIFO; dropped silently if full.
  - 01: bit0 flushes TX FIFO; bit1 flushes RX FIFO and clears error bits.
  - 10/11: divisor low/high byte.
- Reads (iocs & iorw), combinational databus:
  - 00: RX FIFO head, popped on that cycle. When empty, returns 0x00 and no pop occurs.
  - 01: status = {2'b0, tx_idle, parity_err, frame_err, overrun, tbr, rda}; the read clears overrun, frame_err and parity_err on that cycle.
  - 10/11: divisor bytes.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - Each state lasts 16 ticks.
  - LSB first; STOP is 1 bit.
  - Pops the next byte in IDLE when the FIFO is non-empty; back-to-back frames have no idle gap.
  - tx_idle = FIFO empty & FSM IDLE.
- RX path:
  - rxd passes a 2-flop synchroniser.
  - RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: a falling edge starts the frame. START: rxd resampled at tick 8; if high, false start and return to IDLE.
  - Bits are sampled at mid-bit (every 16 ticks thereafter).
  - STOP sampled low: frame_err set, byte still pushed.
  - Push with RX FIFO full: byte discarded, overrun set.
  - A status read in the same cycle as an error set: the set wins.
- FIFOs:
  - Simultaneous push and pop when full or empty are both legal; count stays consistent.
  - Pointers wrap modulo FIFO_DEPTH.
  - A flush has priority over a push in the same cycle.
- Latency: first txd falling edge 1 clk after the first tick following the write; rda rises 1 clk after STOP mid-sample.

Optional Feature:
- Macro: SPART_PARITY_EN.
- Defined:
  - Control bit2 enables parity; bit3 selects odd (1) or even (0).
  - TX inserts a PARITY bit after DATA.
  - RX checks the parity bit and sets parity_err on mismatch; the byte is still pushed.
- Undefined:
  - No PARITY state is generated.
  - Control bits 2/3 are ignored; status bit4 reads 0.

Decomposition:
- Package spart_pkg:
  - ioaddr constants ADDR_DATA/ADDR_STAT/ADDR_DIVL/ADDR_DIVH.
  - Status bit indices.
  - TX/RX state enums.
  - OVERSAMPLE=16 and MID_SAMPLE=8.
- Sub-module spart_sync_fifo (WIDTH, DEPTH), instantiated twice, with ports push/pop/flush/full/empty/dout.
- Baud counter and both FSMs stay in spart_fifo.

Test Plan:
- Reset: hold rst_n=0 mid-frame, then release -> txd=1, tbr=1, rda=0, status=0x22, divisor reads 0x028A.
- TX: divisor=3; write 0xA5 to 00 -> txd low for 64 clk, then bits 1,0,1,0,0,1,0,1 at 64 clk each, stop high; tx_idle=1 after 640 clk.
- Loopback, txd to rxd: write 0x00, 0xFF, 0x3C back-to-back -> rda=1, reads return the same bytes in order, then rda=0 and a further data read returns 0x00.
- Overrun: DEPTH=8, send 9 frames without reading -> 8 bytes retained, status bit2=1, irq=1; status read clears bit2, and a second read shows bit2=0.
- Framing and false start:
  - 4-tick low glitch on rxd -> no push.
  - Frame with stop bit driven 0 -> byte pushed, status bit3=1.
- Parity (SPART_PARITY_EN): odd parity, send 0x01 with parity bit 1 -> parity_err set; with parity bit 0 -> no error.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared constants, status bit layout and FSM state types for the spart_fifo UART.
// The PARITY states exist only when SPART_PARITY_EN is defined.
package spart_pkg;

  localparam logic [1:0] ADDR_DATA = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DIVL = 2'b10;
  localparam logic [1:0] ADDR_DIVH = 2'b11;

  localparam int unsigned ST_RDA     = 0;
  localparam int unsigned ST_TBR     = 1;
  localparam int unsigned ST_OVERRUN = 2;
  localparam int unsigned ST_FRAME   = 3;
  localparam int unsigned ST_PARITY  = 4;
  localparam int unsigned ST_TX_IDLE = 5;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 8;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef SPART_PARITY_EN
    TX_PARITY = 3'd3,
`endif
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
`ifdef SPART_PARITY_EN
    RX_PARITY = 3'd3,
`endif
    RX_STOP   = 3'd4
  } rx_state_t;

  // Parity bit that makes the frame's one-count even (odd=0) or odd (odd=1).
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/spart_sync_fifo.sv
// Synchronous FIFO with combinational head output, flush and count-based full/empty.
// DEPTH must be a power of two; pointers wrap naturally.
module spart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spart_fifo.sv
// Programmable-baud UART with TX/RX FIFOs, sticky error status and interrupt.
// Define SPART_PARITY_EN to add the optional parity bit (control bits 2/3, status bit 4).
module spart_fifo
  import spart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd650
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  logic [7:0] databus,
  input  logic       rxd,
  output logic       txd,
  output logic       rda,
  output logic       tbr,
  output logic       irq
);

  logic                 wr, rd, stat_rd, tx_flush, rx_flush;
  logic [7:0]           rd_data, status;
  logic [15:0]          divisor, baud_cnt;
  logic                 tick;
  logic                 txf_full, txf_empty, rxf_full, rxf_empty, rxf_pop;
  logic [DATA_BITS-1:0] txf_dout, rxf_dout;
  logic                 overrun, frame_err, parity_err, tx_idle;
  logic                 par_en, par_odd;

  assign wr       = iocs & ~iorw;
  assign rd       = iocs & iorw;
  assign stat_rd  = rd & (ioaddr == ADDR_STAT);
  assign tx_flush = wr & (ioaddr == ADDR_STAT) & databus[0];
  assign rx_flush = wr & (ioaddr == ADDR_STAT) & databus[1];
  assign rxf_pop  = rd & (ioaddr == ADDR_DATA) & ~rxf_empty;
  assign databus  = rd ? rd_data : 'z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor <= DIV_RESET;
    end else if (wr && ioaddr == ADDR_DIVL) begin
      divisor[7:0] <= databus;
    end else if (wr && ioaddr == ADDR_DIVH) begin
      divisor[15:8] <= databus;
    end
  end

`ifdef SPART_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_en  <= 1'b0;
      par_odd <= 1'b0;
    end else if (wr && ioaddr == ADDR_STAT) begin
      par_en  <= databus[2];
      par_odd <= databus[3];
    end
  end
`else
  assign par_en  = 1'b0;
  assign par_odd = 1'b0;
`endif

  // Divisor changes are only picked up at reload, so a running frame keeps its bit timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               baud_cnt <= DIV_RESET;
    else if (baud_cnt == '0)  baud_cnt <= divisor;
    else                      baud_cnt <= baud_cnt - 1'b1;
  end
  assign tick = (baud_cnt == '0);

  // ---------------- transmitter ----------------
  tx_state_t            tx_state, tx_next;
  logic                 tx_pop, tx_bit_end, tx_last_bit, tx_par;
  logic [3:0]           tx_tcnt;
  logic [2:0]           tx_bcnt;
  logic [DATA_BITS-1:0] tx_shreg;

  spart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr && ioaddr == ADDR_DATA),
    .pop   (tx_pop),
    .flush (tx_flush),
    .din   (databus[DATA_BITS-1:0]),
    .dout  (txf_dout),
    .full  (txf_full),
    .empty (txf_empty)
  );

  assign tx_bit_end  = tick & (tx_tcnt == 4'(OVERSAMPLE-1));
  assign tx_last_bit = (tx_bcnt == 3'(DATA_BITS-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:   if (tx_pop) tx_next = TX_START;
      TX_START:  if (tx_bit_end) tx_next = TX_DATA;
      TX_DATA: begin
        if (tx_bit_end && tx_last_bit) begin
`ifdef SPART_PARITY_EN
          tx_next = par_en ? TX_PARITY : TX_STOP;
`else
          tx_next = TX_STOP;
`endif
        end
      end
`ifdef SPART_PARITY_EN
      TX_PARITY: if (tx_bit_end) tx_next = TX_STOP;
`endif
      TX_STOP:   if (tx_bit_end) tx_next = tx_pop ? TX_START : TX_IDLE;
      default:   tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    txd    = 1'b1;
    tx_pop = 1'b0;
    case (tx_state)
      TX_IDLE:   tx_pop = tick & ~txf_empty;
      TX_START:  txd = 1'b0;
      TX_DATA:   txd = tx_shreg[0];
`ifdef SPART_PARITY_EN
      TX_PARITY: txd = tx_par;
`endif
      TX_STOP:   tx_pop = tx_bit_end & ~txf_empty;
      default:   txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shreg <= '0;
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
      tx_par   <= 1'b0;
    end else if (tx_pop) begin
      tx_shreg <= txf_dout;
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
      tx_par   <= calc_parity(8'(txf_dout), par_odd);
    end else if (tick && tx_state != TX_IDLE) begin
      tx_tcnt <= tx_tcnt + 1'b1;
      if (tx_bit_end && tx_state == TX_DATA) begin
        tx_shreg <= tx_shreg >> 1;
        tx_bcnt  <= tx_bcnt + 1'b1;
      end
    end
  end

  // ---------------- receiver ----------------
  rx_state_t            rx_state, rx_next;
  logic [2:0]           rx_sync;
  logic                 rxs, rx_fall, rx_mid, rx_bit_end, rx_last_bit, rx_push;
  logic                 rx_par_bit;
  logic [3:0]           rx_tcnt;
  logic [2:0]           rx_bcnt;
  logic [DATA_BITS-1:0] rx_shreg;

  // Two synchroniser flops, third flop only for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sync <= '1;
    else        rx_sync <= {rx_sync[1:0], rxd};
  end
  assign rxs     = rx_sync[1];
  assign rx_fall = rx_sync[2] & ~rx_sync[1];

  assign rx_mid      = tick & (rx_tcnt == 4'(MID_SAMPLE-1));
  assign rx_bit_end  = tick & (rx_tcnt == 4'(OVERSAMPLE-1));
  assign rx_last_bit = (rx_bcnt == 3'(DATA_BITS-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:   if (rx_fall) rx_next = RX_START;
      RX_START:  if (rx_mid) rx_next = rxs ? RX_IDLE : RX_DATA;
      RX_DATA: begin
        if (rx_bit_end && rx_last_bit) begin
`ifdef SPART_PARITY_EN
          rx_next = par_en ? RX_PARITY : RX_STOP;
`else
          rx_next = RX_STOP;
`endif
        end
      end
`ifdef SPART_PARITY_EN
      RX_PARITY: if (rx_bit_end) rx_next = RX_STOP;
`endif
      RX_STOP:   if (rx_bit_end) rx_next = RX_IDLE;
      default:   rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_push = (rx_state == RX_STOP) & rx_bit_end;
  end

  // Counter restarts at the start-bit midpoint so later samples land mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_tcnt    <= '0;
      rx_bcnt    <= '0;
      rx_shreg   <= '0;
      rx_par_bit <= 1'b0;
    end else begin
      if (rx_state == RX_IDLE)                   rx_tcnt <= '0;
      else if (rx_state == RX_START && rx_mid)   rx_tcnt <= '0;
      else if (tick)                             rx_tcnt <= rx_tcnt + 1'b1;
      if (rx_state == RX_START) rx_bcnt <= '0;
      if (rx_state == RX_DATA && rx_bit_end) begin
        rx_shreg <= {rxs, rx_shreg[DATA_BITS-1:1]};
        rx_bcnt  <= rx_bcnt + 1'b1;
      end
`ifdef SPART_PARITY_EN
      if (rx_state == RX_PARITY && rx_bit_end) rx_par_bit <= rxs;
`endif
    end
  end

  spart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .pop   (rxf_pop),
    .flush (rx_flush),
    .din   (rx_shreg),
    .dout  (rxf_dout),
    .full  (rxf_full),
    .empty (rxf_empty)
  );

  // Clears come first so a new error in the same cycle survives a status read or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (stat_rd || rx_flush) begin
        overrun    <= 1'b0;
        frame_err  <= 1'b0;
        parity_err <= 1'b0;
      end
      if (rx_push && rxf_full && !rxf_pop) overrun <= 1'b1;
      if (rx_push && !rxs)                 frame_err <= 1'b1;
      if (rx_push && par_en && (rx_par_bit != calc_parity(8'(rx_shreg), par_odd)))
        parity_err <= 1'b1;
    end
  end

  assign rda     = ~rxf_empty;
  assign tbr     = ~txf_full;
  assign tx_idle = txf_empty & (tx_state == TX_IDLE);
  assign irq     = rda | overrun | frame_err | parity_err;

  always_comb begin
    status             = '0;
    status[ST_RDA]     = rda;
    status[ST_TBR]     = tbr;
    status[ST_OVERRUN] = overrun;
    status[ST_FRAME]   = frame_err;
    status[ST_PARITY]  = parity_err;
    status[ST_TX_IDLE] = tx_idle;
  end

  always_comb begin
    rd_data = '0;
    case (ioaddr)
      ADDR_DATA: if (!rxf_empty) rd_data[DATA_BITS-1:0] = rxf_dout;
      ADDR_STAT: rd_data = status;
      ADDR_DIVL: rd_data = divisor[7:0];
      ADDR_DIVH: rd_data = divisor[15:8];
      default:   rd_data = '0;
    endcase
  end

endmodule
